// File: rtl/neuron_ctrl_pkg.sv
// Shared definitions for the neuron event scheduler: FSM encoding, default
// array dimensions and the sweep-length helpers used to size the counters.
package neuron_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PRE_RD,
    PRE_WR,
    POST_RD,
    POST_WR,
    TS_RD,
    TS_WR,
    TR_PRE_RD,
    TR_PRE_WR,
    TR_POST_RD,
    TR_POST_WR
  } sched_state_t;

  localparam int DEF_TIME_STEP          = 8;
  localparam int DEF_INPUT_NEURON       = 784;
  localparam int DEF_OUTPUT_NEURON      = 256;
  localparam int DEF_POST_NEUR_PARALLEL = 4;

  // Number of pre-SRAM words visited by a state-clear sweep.
  function automatic int pre_sweep_len(input int input_neuron);
    return input_neuron;
  endfunction

  // Number of post-SRAM words (groups of parallel neurons) in a post sweep.
  function automatic int post_group_count(input int output_neuron, input int parallel);
    return output_neuron / parallel;
  endfunction

endpackage

// File: rtl/sweep_counter.sv
// Loadable up-counter with a terminal-count flag; walks SRAM words during
// both the pre-neuron and post-neuron sweeps.
module sweep_counter #(
  parameter int WIDTH = 10,
  parameter int LAST  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (inc) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == WIDTH'(LAST));

endmodule

// File: rtl/neuron_event_scheduler.sv
// Sequences SRAM read/write sweeps for spike events, time-step updates and
// end-of-sample state clears, arbitrating between them when idle.
module neuron_event_scheduler
  import neuron_ctrl_pkg::*;
#(
  parameter int TIME_STEP            = DEF_TIME_STEP,
  parameter int INPUT_NEURON         = DEF_INPUT_NEURON,
  parameter int OUTPUT_NEURON        = DEF_OUTPUT_NEURON,
  parameter int POST_NEUR_PARALLEL   = DEF_POST_NEUR_PARALLEL,
  parameter int PRE_NEUR_ADDR_WIDTH  = 10,
  parameter int POST_NEUR_ADDR_WIDTH = 10
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            AER_REQ,
  input  logic [PRE_NEUR_ADDR_WIDTH-1:0]  AER_ADDR,
  output logic                            AER_ACK,
  input  logic                            TSTEP_REQ,
  input  logic                            TREF_REQ,
  input  logic                            SPI_GATE_ACTIVITY_sync,
  output logic [PRE_NEUR_ADDR_WIDTH-1:0]  CTRL_PRE_NEURON_ADDRESS,
  output logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS,
  output logic                            CTRL_PRE_NEUR_CS,
  output logic                            CTRL_PRE_NEUR_WE,
  output logic                            CTRL_POST_NEUR_CS,
  output logic                            CTRL_POST_NEUR_WE,
  output logic                            CTRL_NEUR_EVENT,
  output logic                            CTRL_PRE_CNT_EN,
  output logic                            CTRL_TSTEP_EVENT,
  output logic                            CTRL_TREF_EVENT,
  output logic [$clog2(TIME_STEP)-1:0]    CURRENT_TIME_STEP,
  output logic                            BUSY,
  output logic                            SAMPLE_DONE
);

  localparam int TS_W   = $clog2(TIME_STEP);
  localparam int GROUPS = post_group_count(OUTPUT_NEURON, POST_NEUR_PARALLEL);
  localparam logic [TS_W-1:0] TS_LAST = TS_W'(TIME_STEP - 1);

  sched_state_t state_reg, state_next;

  logic tref_pend_reg, tstep_pend_reg, ack_reg, sample_done_reg;
  logic [TS_W-1:0] tstep_reg;
  logic tref_any, tstep_any;
  logic start_tref, start_tstep, start_aer, ts_done, tr_done;
  logic pre_load, pre_inc, post_load, post_inc, pre_tc, post_tc;
  logic [PRE_NEUR_ADDR_WIDTH-1:0]  pre_load_value, pre_count;
  logic [POST_NEUR_ADDR_WIDTH-1:0] post_count;

  // A pulse arriving in the arbitration cycle counts as already pending.
  assign tref_any  = tref_pend_reg | TREF_REQ;
  assign tstep_any = tstep_pend_reg | TSTEP_REQ;

  sweep_counter #(
    .WIDTH (PRE_NEUR_ADDR_WIDTH),
    .LAST  (pre_sweep_len(INPUT_NEURON) - 1)
  ) u_pre_counter (
    .clk        (CLK),
    .rst        (RST),
    .load       (pre_load),
    .load_value (pre_load_value),
    .inc        (pre_inc),
    .count      (pre_count),
    .tc         (pre_tc)
  );

  sweep_counter #(
    .WIDTH (POST_NEUR_ADDR_WIDTH),
    .LAST  (GROUPS - 1)
  ) u_post_counter (
    .clk        (CLK),
    .rst        (RST),
    .load       (post_load),
    .load_value ('0),
    .inc        (post_inc),
    .count      (post_count),
    .tc         (post_tc)
  );

  assign CTRL_PRE_NEURON_ADDRESS  = pre_count;
  assign CTRL_POST_NEURON_ADDRESS = post_count * POST_NEUR_ADDR_WIDTH'(POST_NEUR_PARALLEL);
  assign CURRENT_TIME_STEP        = tstep_reg;
  assign AER_ACK                  = ack_reg;
  assign SAMPLE_DONE              = sample_done_reg;
  assign BUSY                     = (state_reg != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    start_tref        = 1'b0;
    start_tstep       = 1'b0;
    start_aer         = 1'b0;
    ts_done           = 1'b0;
    tr_done           = 1'b0;
    pre_load          = 1'b0;
    pre_load_value    = '0;
    pre_inc           = 1'b0;
    post_load         = 1'b0;
    post_inc          = 1'b0;
    CTRL_PRE_NEUR_CS  = 1'b0;
    CTRL_PRE_NEUR_WE  = 1'b0;
    CTRL_POST_NEUR_CS = 1'b0;
    CTRL_POST_NEUR_WE = 1'b0;
    CTRL_NEUR_EVENT   = 1'b0;
    CTRL_PRE_CNT_EN   = 1'b0;
    CTRL_TSTEP_EVENT  = 1'b0;
    CTRL_TREF_EVENT   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!SPI_GATE_ACTIVITY_sync) begin
          if (tref_any) begin
            start_tref = 1'b1;
            pre_load   = 1'b1;
            post_load  = 1'b1;
            state_next = TR_PRE_RD;
          end else if (tstep_any) begin
            start_tstep = 1'b1;
            post_load   = 1'b1;
            state_next  = TS_RD;
          end else if (AER_REQ) begin
            start_aer      = 1'b1;
            pre_load       = 1'b1;
            pre_load_value = AER_ADDR;
            post_load      = 1'b1;
            state_next     = PRE_RD;
          end
        end
      end
      PRE_RD: begin
        CTRL_PRE_NEUR_CS = 1'b1;
        state_next       = PRE_WR;
      end
      PRE_WR: begin
        CTRL_PRE_NEUR_CS = 1'b1;
        CTRL_PRE_NEUR_WE = 1'b1;
        CTRL_NEUR_EVENT  = 1'b1;
        CTRL_PRE_CNT_EN  = 1'b1;
        state_next       = POST_RD;
      end
      POST_RD: begin
        CTRL_POST_NEUR_CS = 1'b1;
        state_next        = POST_WR;
      end
      POST_WR: begin
        CTRL_POST_NEUR_CS = 1'b1;
        CTRL_POST_NEUR_WE = 1'b1;
        CTRL_NEUR_EVENT   = 1'b1;
        post_inc          = !post_tc;
        state_next        = post_tc ? IDLE : POST_RD;
      end
      TS_RD: begin
        CTRL_POST_NEUR_CS = 1'b1;
        state_next        = TS_WR;
      end
      TS_WR: begin
        CTRL_POST_NEUR_CS = 1'b1;
        CTRL_POST_NEUR_WE = 1'b1;
        CTRL_TSTEP_EVENT  = 1'b1;
        post_inc          = !post_tc;
        ts_done           = post_tc;
        state_next        = post_tc ? IDLE : TS_RD;
      end
      TR_PRE_RD: begin
        CTRL_PRE_NEUR_CS = 1'b1;
        state_next       = TR_PRE_WR;
      end
      TR_PRE_WR: begin
        CTRL_PRE_NEUR_CS = 1'b1;
        CTRL_PRE_NEUR_WE = 1'b1;
        CTRL_TREF_EVENT  = 1'b1;
        pre_inc          = !pre_tc;
        state_next       = pre_tc ? TR_POST_RD : TR_PRE_RD;
      end
      TR_POST_RD: begin
        CTRL_POST_NEUR_CS = 1'b1;
        state_next        = TR_POST_WR;
      end
      TR_POST_WR: begin
        CTRL_POST_NEUR_CS = 1'b1;
        CTRL_POST_NEUR_WE = 1'b1;
        CTRL_TREF_EVENT   = 1'b1;
        post_inc          = !post_tc;
        tr_done           = post_tc;
        state_next        = post_tc ? IDLE : TR_POST_RD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Starting a state clear also discards any time step queued behind it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tref_pend_reg   <= 1'b0;
      tstep_pend_reg  <= 1'b0;
      ack_reg         <= 1'b0;
      sample_done_reg <= 1'b0;
      tstep_reg       <= '0;
    end else begin
      tref_pend_reg   <= start_tref ? 1'b0 : tref_any;
      tstep_pend_reg  <= (start_tref || start_tstep) ? 1'b0 : tstep_any;
      ack_reg         <= start_aer;
      sample_done_reg <= ts_done && (tstep_reg == TS_LAST);
      if (tr_done) begin
        tstep_reg <= '0;
      end else if (ts_done) begin
        tstep_reg <= (tstep_reg == TS_LAST) ? '0 : tstep_reg + TS_W'(1);
      end
    end
  end

endmodule

// File: doc/neuron_event_scheduler.md
NEURON_EVENT_SCHEDULER -- requirements
Module: neuron_event_scheduler

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- TIME_STEP, 8, time steps per sample
- INPUT_NEURON, 784, pre-neuron count
- OUTPUT_NEURON, 256, post-neuron count
- POST_NEUR_PARALLEL, 4, post neurons per SRAM word
- PRE_NEUR_ADDR_WIDTH, 10, pre address width
- POST_NEUR_ADDR_WIDTH, 10, post address width
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- CLK, in, 1, single clock, rising edge
- RST, in, 1, reset, asynchronous, active-high
- AER_REQ, in, 1, input spike event request
- AER_ADDR, in, PRE_NEUR_ADDR_WIDTH, spiking pre-neuron index
- AER_ACK, out, 1, event accepted
- TSTEP_REQ, in, 1, end-of-time-step pulse
- TREF_REQ, in, 1, end-of-sample (state clear) pulse
- SPI_GATE_ACTIVITY_sync, in, 1, SPI owns SRAMs; block new work
- CTRL_PRE_NEURON_ADDRESS, out, PRE_NEUR_ADDR_WIDTH, pre SRAM address
- CTRL_POST_NEURON_ADDRESS, out, POST_NEUR_ADDR_WIDTH, post neuron address (group*POST_NEUR_PARALLEL)
- CTRL_PRE_NEUR_CS / CTRL_PRE_NEUR_WE, out, 1 each, pre SRAM select/write
- CTRL_POST_NEUR_CS / CTRL_POST_NEUR_WE, out, 1 each, post SRAM select/write
- CTRL_NEUR_EVENT, out, 1, synaptic-integration update strobe
- CTRL_PRE_CNT_EN, out, 1, pre spike-count increment pulse
- CTRL_TSTEP_EVENT, out, 1, time-step fire/update strobe
- CTRL_TREF_EVENT, out, 1, state-clear strobe
- CURRENT_TIME_STEP, out, clog2(TIME_STEP), current step index
- BUSY, out, 1, state != IDLE
- SAMPLE_DONE, out, 1, one-cycle pulse after last time step

Function
REQ-003 SHALL implement FSM states IDLE, PRE_RD, PRE_WR, POST_RD, POST_WR, TS_RD, TS_WR, TR_PRE_RD, TR_PRE_WR, TR_POST_RD, TR_POST_WR.
REQ-004 SHALL latch TSTEP_REQ and TREF_REQ pulses into pending flags; a flag clears when its operation starts.
REQ-005 In IDLE with SPI_GATE_ACTIVITY_sync=0, SHALL start work with priority TREF pending > TSTEP pending > AER_REQ; gate=1 starts nothing, and an in-flight operation completes.
REQ-006 AER accept SHALL pulse AER_ACK for exactly one cycle, latch AER_ADDR, go to PRE_RD.
REQ-007 PRE_RD: pre CS=1, WE=0. PRE_WR: pre CS=1, WE=1, CTRL_NEUR_EVENT=1, CTRL_PRE_CNT_EN=1 (one cycle).
REQ-008 Post sweep: group g = 0..OUTPUT_NEURON/POST_NEUR_PARALLEL-1.
- *_RD: post CS=1, WE=0.
- *_WR: post CS=1, WE=1, with the operation strobe (NEUR/TSTEP/TREF) held high.
- Address = g*POST_NEUR_PARALLEL.
- After the last group, return to IDLE.
REQ-009 AER operation SHALL take 2+2*64 = 130 cycles at defaults. TSTEP operation SHALL take 128 cycles.
REQ-010 TREF operation SHALL sweep all INPUT_NEURON pre addresses (rd/wr pairs, CTRL_TREF_EVENT=1 on write), then the post sweep: 1568+128 = 1696 cycles at defaults.
REQ-011 At end of a TSTEP sweep, CURRENT_TIME_STEP SHALL increment, wrapping TIME_STEP-1 -> 0; the wrap pulses SAMPLE_DONE.
REQ-012 TREF completion SHALL set CURRENT_TIME_STEP=0; starting TREF SHALL clear a pending TSTEP.
REQ-013 In IDLE all CS/WE/strobes SHALL be 0; addresses SHALL hold their last value.
REQ-014 TSTEP_REQ/TREF_REQ arriving while BUSY SHALL be remembered, not lost; duplicate pulses before service collapse into one.

Reset
REQ-015 RST=1 SHALL immediately force IDLE, clear all outputs, counters, pending flags and CURRENT_TIME_STEP to 0, including mid-sweep.

Structure
REQ-016 State encoding, sweep lengths and group count SHALL live in package neuron_ctrl_pkg.
REQ-017 One sub-module, sweep_counter (load, increment, terminal-count flag), SHALL be used for both pre and post sweeps.

Verification
REQ-018 Directed scenarios:
- Reset release: all outputs 0, BUSY=0, CURRENT_TIME_STEP=0.
- AER_ADDR=5: one-cycle ACK; pre address 5 rd then wr with PRE_CNT_EN; 64 post writes at 0,4,...,252; BUSY for 130 cycles.
- 8 TSTEP pulses: CURRENT_TIME_STEP 1..7 then 0; SAMPLE_DONE on the 8th only.
- TREF, TSTEP and AER in the same cycle: TREF runs 1696 cycles, then AER; TSTEP is dropped.
- Gate=1 with AER_REQ held: no ACK; ACK one cycle after gate falls.
- RST asserted mid post sweep (g=30): next cycle IDLE, all strobes 0, pending flags cleared.
